fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised operand-forwarding and load-use hazard unit for the RV32I decode stage. Tracks the destination registers of the instructions in flight after decode in an internal shift pipeline of NSTAGE entries. Each cycle it either forwards the youngest available matching result to each decode operand or raises a decode stall. It replaces the fixed single-stage, load-excluding bypass with a configurable depth and load-latency model, flush handling and a stall counter.

## Interface
Parameters:
- XLEN, 32, datapath width
- NSTAGE, 3, tracked stages after decode (index 0 = E, 1 = M, 2 = W)
- LOAD_LAT, 2, lowest stage index at which a load result may be forwarded; legal range 0..NSTAGE-1
- CNTW, 16, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- issue_valid  in  1  instruction in D advances to E this cycle
- issue_rd  in  5  its destination register
- issue_we  in  1  it writes the register file
- issue_load  in  1  it is a load
- flush  in  1  kill the instruction entering E this cycle
- rs1D, rs2D  in  5  decode source registers
- rs1_use, rs2_use  in  1  each operand is actually read
- source1D, source2D  in  XLEN  register-file read data
- stage_result  in  NSTAGE*XLEN  result of the instruction at stage i, in slice [i*XLEN +: XLEN]
- reg_data1D, reg_data2D  out  XLEN  resolved operands
- stallD  out  1  hold F/D, insert bubble into E
- stall_cnt  out  CNTW  saturating count of stall cycles

## Operation
- Entry fields: valid, rd, we, load. Entry i is "live for rs" when valid & we & rd==rs & rd!=0.
- Availability: a non-load entry is available at every index; a load entry is available only when i >= LOAD_LAT.
- Per-operand search runs from index 0 upward. The first live entry decides the operand:
  - If it is available, the operand is stage_result[i].
  - Otherwise the operand is a hazard, and the operand output is source*D (don't-care).
  - If there is no live entry, the operand is source*D.
- A younger unavailable match hides older available ones. Stalling on it is mandatory.
- rs==0 never matches, so register-file data (zero) passes through.
- stallD = (rs1_use & hazard1) | (rs2_use & hazard2). An unused operand never stalls, but its data output still follows the rules above.
- Shift at every posedge. Entry[i] takes entry[i-1]. Entry[0] takes the issue fields when issue_valid & !stallD & !flush; otherwise it becomes an invalid bubble.
- The entry leaving index NSTAGE-1 is discarded. The register file then holds its value.
- flush only blocks capture into entry 0. Entries already in flight are unaffected.
- stall_cnt increments on each cycle with stallD=1 and saturates at all-ones.
- Reset (rst_n=0 at a posedge), including mid-stall: all entries go invalid and stall_cnt goes to 0. With entries invalid, the combinational outputs are stallD=0 and reg_data*D=source*D.

## Timing
- Forwarding and stallD are combinational from the current entries and inputs. Latency is 0 cycles.
- Entry state updates at the posedge only.
- Load-use with a dependent instruction immediately behind the load: the stall lasts exactly LOAD_LAT cycles, after which the load result is forwarded.
  - Example, default parameters: load issued at edge t. The dependent instruction stalls in cycles t+1 and t+2, and forwards stage_result[2] in t+3.
- ALU-to-ALU dependence: never stalls. It forwards stage_result[0] in the cycle after the producer issues.
- Simultaneous stallD and issue_valid: the issue is not captured. Upstream holds the instruction and re-presents it.
- Simultaneous flush and issue_valid: a bubble enters E.
- A dependence on an instruction more than NSTAGE stages old resolves via source*D. The register file must write-before-read.

## Structure
- Shared package holds:
  - entry field constants (REG_AW=5, REG_ZERO=5'd0)
  - the entry record layout (valid, rd, we, load)
- One sub-module, fwd_match, instantiated once per operand. It takes the entry vector, rs, stage_result and source. It returns the operand data and the hazard bit, using a priority search parametrised by NSTAGE and LOAD_LAT.
- The top level owns the shift register, the stall combine and stall_cnt.

## Test plan
- ALU chain: issue add x5 (we, non-load); the next cycle rs1D=5 with stage_result[0]=0x1234 → reg_data1D=0x1234, stallD=0.
- Load-use, defaults: issue load x7; the next cycle rs2D=7, rs2_use=1 → stallD=1 for 2 cycles and stall_cnt=2; in the third cycle reg_data2D=stage_result[2].
- Shadowing: add x3 at index 1 and load x3 at index 0, rs1D=3 → stallD=1 (no forward from index 1).
- x0 and unused operands: issue add x0, then rs1D=0 → reg_data1D=source1D; load x9 followed by rs1D=9 with rs1_use=0 → stallD=0.
- Flush and reset: flush with issue_valid, rd=4, then rs1D=4 → no match, source1D used. Assert rst_n=0 during a load stall → next cycle stallD=0 and stall_cnt=0.
- Saturation: CNTW=2 with a continuous stall for 5 cycles → stall_cnt holds 3.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
`default_nettype none
// =============================================================================
// Module   : fwd_scoreboard_pkg
// Purpose  : Shared entry layout and register-field constants for the scoreboard.
// Revision : 1.0
// =============================================================================
package fwd_scoreboard_pkg;

    localparam int          REG_AW   = 5;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
    } entry_t;

endpackage : fwd_scoreboard_pkg
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// =============================================================================
// Module   : fwd_match
// Purpose  : Youngest-first forwarding search for one decode operand.
// Revision : 1.0
// =============================================================================
module fwd_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NSTAGE   = 3,
    parameter int LOAD_LAT = 2
) (
    input  entry_t [NSTAGE-1:0]      entries_i,
    input  logic   [REG_AW-1:0]      rs_i,
    input  logic   [NSTAGE*XLEN-1:0] stage_result_i,
    input  logic   [XLEN-1:0]        source_i,
    output logic   [XLEN-1:0]        data_o,
    output logic                     hazard_o
);

    logic w_found;

    // The first live entry decides; an unavailable load hides older producers.
    always_comb begin
        data_o   = source_i;
        hazard_o = 1'b0;
        w_found  = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (!w_found && entries_i[i].valid && entries_i[i].we &&
                (entries_i[i].rd == rs_i) && (rs_i != REG_ZERO)) begin
                w_found = 1'b1;
                if (!entries_i[i].load || (i >= LOAD_LAT)) begin
                    data_o = stage_result_i[i*XLEN +: XLEN];
                end else begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule : fwd_match
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// =============================================================================
// Module   : fwd_scoreboard
// Purpose  : In-flight destination tracking, operand forwarding and load-use stall.
// Revision : 1.0
// =============================================================================
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NSTAGE   = 3,
    parameter int LOAD_LAT = 2,
    parameter int CNTW     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic [REG_AW-1:0]        issue_rd,
    input  logic                     issue_we,
    input  logic                     issue_load,
    input  logic                     flush,
    input  logic [REG_AW-1:0]        rs1D,
    input  logic [REG_AW-1:0]        rs2D,
    input  logic                     rs1_use,
    input  logic                     rs2_use,
    input  logic [XLEN-1:0]          source1D,
    input  logic [XLEN-1:0]          source2D,
    input  logic [NSTAGE*XLEN-1:0]   stage_result,
    output logic [XLEN-1:0]          reg_data1D,
    output logic [XLEN-1:0]          reg_data2D,
    output logic                     stallD,
    output logic [CNTW-1:0]          stall_cnt
);

    entry_t [NSTAGE-1:0] entries_q;
    entry_t [NSTAGE-1:0] entries_d;
    logic   [CNTW-1:0]   stall_cnt_q;
    logic   [CNTW-1:0]   stall_cnt_d;
    logic                w_hazard1;
    logic                w_hazard2;

    fwd_match #(.XLEN(XLEN), .NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT)) u_match1 (
        .entries_i      (entries_q),
        .rs_i           (rs1D),
        .stage_result_i (stage_result),
        .source_i       (source1D),
        .data_o         (reg_data1D),
        .hazard_o       (w_hazard1)
    );

    fwd_match #(.XLEN(XLEN), .NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT)) u_match2 (
        .entries_i      (entries_q),
        .rs_i           (rs2D),
        .stage_result_i (stage_result),
        .source_i       (source2D),
        .data_o         (reg_data2D),
        .hazard_o       (w_hazard2)
    );

    assign stallD    = (rs1_use & w_hazard1) | (rs2_use & w_hazard2);
    assign stall_cnt = stall_cnt_q;

    // A stalled or flushed issue leaves a bubble in E; upstream re-presents it.
    always_comb begin
        entries_d = '0;
        if (issue_valid && !stallD && !flush) begin
            entries_d[0].valid = 1'b1;
            entries_d[0].rd    = issue_rd;
            entries_d[0].we    = issue_we;
            entries_d[0].load  = issue_load;
        end
        for (int i = 1; i < NSTAGE; i++) begin
            entries_d[i] = entries_q[i-1];
        end
        stall_cnt_d = stall_cnt_q;
        if (stallD && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entries_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            entries_q   <= entries_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule : fwd_scoreboard
`default_nettype wire
